hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum MEM_WAIT cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_count.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have port id_ex_rd, input, 5: destination register held in ID/EX.
REQ-007 SHALL have port id_ex_MemRead, input, 1: ID/EX holds a load.
REQ-008 SHALL have ports ex_mem_Branch and ex_mem_zero, input, 1 each: branch condition held in EX/MEM.
REQ-009 SHALL have ports ex_mem_MemRead and ex_mem_MemWrite, input, 1 each: EX/MEM memory operation.
REQ-010 SHALL have port dmem_ack, input, 1: data memory completes the access this cycle.
REQ-011 SHALL have port dmem_req, output, 1: data memory access request.
REQ-012 SHALL have ports pc_write and if_id_write, output, 1 each: PC and IF/ID enables.
REQ-013 SHALL have ports id_ex_hold and ex_mem_hold, output, 1 each: hold ID/EX and EX/MEM contents.
REQ-014 SHALL have ports if_id_flush, id_ex_flush and ex_mem_flush, output, 1 each: load a bubble, all controls 0.
REQ-015 SHALL have port pc_src, output, 1: select the branch target PC.
REQ-016 SHALL have ports mem_err, output, 1, and stall_count, output, CNT_W: memory timeout flag and stalled-cycle count.

Function
REQ-017 SHALL implement states RUN, MEM_WAIT and ERR in a registered FSM; outputs are decoded from state plus current inputs.
REQ-018 In RUN, a taken branch (ex_mem_Branch & ex_mem_zero) SHALL assert pc_src, if_id_flush, id_ex_flush and ex_mem_flush in the same cycle; the state remains RUN.
REQ-019 In RUN with no taken branch, a memory operation in EX/MEM SHALL assert dmem_req.
REQ-020 In that case, dmem_ack=1 SHALL keep the state in RUN with no stall; dmem_ack=0 SHALL deassert pc_write and if_id_write, assert id_ex_hold and ex_mem_hold, and move the FSM to MEM_WAIT.
REQ-021 In RUN with no branch and no pending access, a load-use hazard SHALL deassert pc_write and if_id_write and assert id_ex_flush for exactly that cycle.
REQ-022 A load-use hazard is id_ex_MemRead & (id_ex_rd != 0) & (id_ex_rd == id_rs1 | id_ex_rd == id_rs2).
REQ-023 Priority SHALL be taken branch > memory wait > load-use.
REQ-024 In MEM_WAIT, dmem_req SHALL stay 1, all stage enables SHALL stay held, and load-use and branch detection SHALL be suppressed.
REQ-025 In MEM_WAIT, an internal wait counter SHALL increment each cycle; dmem_ack=1 releases all holds in that cycle and returns the FSM to RUN.
REQ-026 When the wait count reaches MEM_TIMEOUT without ack, the FSM SHALL enter ERR.
REQ-027 In ERR, mem_err SHALL be 1, all stages SHALL be held, dmem_req SHALL be 0, and the FSM SHALL leave ERR only on reset.
REQ-028 stall_count SHALL increment on every cycle in which pc_write=0 and SHALL saturate at all-ones, never wrapping.
REQ-029 If dmem_ack and the timeout occur in the same cycle, ack SHALL win and the FSM SHALL return to RUN.
REQ-030 The wait counter SHALL clear on every entry to MEM_WAIT.

Reset
REQ-031 When rst_n=0 at a clk edge, the FSM SHALL go to RUN, the wait counter and stall_count SHALL clear, and mem_err SHALL clear, including mid-MEM_WAIT.
REQ-032 While rst_n=0, outputs SHALL be pc_write=1, if_id_write=1, and all hold, flush, pc_src and dmem_req outputs 0.

Structure
REQ-033 The state enum and register-index width SHALL live in shared package pipe_pkg.
REQ-034 The saturating stall counter SHALL be sub-module sat_counter, parameterised by width.

Verification
REQ-035 id_ex_MemRead=1, id_ex_rd=5, id_rs2=5 -> one cycle of pc_write=0, id_ex_flush=1; stall_count=1.
REQ-036 Same as REQ-035 with id_ex_rd=0 -> no stall.
REQ-037 ex_mem_Branch=1, ex_mem_zero=1 together with a load-use hazard -> pc_src and all three flushes asserted, pc_write=1.
REQ-038 ex_mem_MemRead=1, dmem_ack arriving after 3 cycles -> holds asserted 3 cycles, release in the ack cycle; stall_count=3.
REQ-039 ex_mem_MemWrite=1 with no ack -> mem_err=1 after 15 wait cycles; rst_n=0 -> mem_err=0, state RUN.
REQ-040 rst_n=0 during MEM_WAIT cycle 2 -> next cycle all holds 0, dmem_req=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: controller states, register-index
// width, the bundle of stage-control signals and the load-use test.
package pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Everything the controller drives into the pipeline in one cycle.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pc_src;
        logic dmem_req;
    } ctrl_t;

    // Free-running pipeline: PC and IF/ID advance, nothing held or flushed.
    localparam ctrl_t CTRL_FREE = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        id_ex_hold:   1'b0,
        ex_mem_hold:  1'b0,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_flush: 1'b0,
        pc_src:       1'b0,
        dmem_req:     1'b0
    };

    // A load in ID/EX whose destination (other than x0) is read by the
    // instruction in ID.
    function automatic logic load_use_hazard(
        input logic     mem_read,
        input reg_idx_t rd,
        input reg_idx_t rs1,
        input reg_idx_t rs2
    );
        return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: taken-branch flush, data-memory wait stalls
// with timeout, and load-use interlock, plus a stalled-cycle counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_MemRead,
    input  logic             ex_mem_Branch,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_MemRead,
    input  logic             ex_mem_MemWrite,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_src,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    ctrl_t             w_ctrl;
    logic              w_branch_taken;
    logic              w_mem_op;
    logic              w_load_use;

    assign w_branch_taken = ex_mem_Branch & ex_mem_zero;
    assign w_mem_op       = ex_mem_MemRead | ex_mem_MemWrite;
    assign w_load_use     = load_use_hazard(id_ex_MemRead, id_ex_rd, id_rs1, id_rs2);

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next state and stage controls from state plus current inputs,
    // priority branch > memory wait > load-use; reset forces a free pipe.
    always_comb begin
        w_ctrl       = CTRL_FREE;
        w_state_next = r_state;
        w_wait_next  = r_wait;

        unique case (r_state)
            RUN: begin
                if (w_branch_taken) begin
                    w_ctrl.pc_src       = 1'b1;
                    w_ctrl.if_id_flush  = 1'b1;
                    w_ctrl.id_ex_flush  = 1'b1;
                    w_ctrl.ex_mem_flush = 1'b1;
                end else if (w_mem_op) begin
                    w_ctrl.dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        w_ctrl.pc_write    = 1'b0;
                        w_ctrl.if_id_write = 1'b0;
                        w_ctrl.id_ex_hold  = 1'b1;
                        w_ctrl.ex_mem_hold = 1'b1;
                        w_state_next       = MEM_WAIT;
                        w_wait_next        = '0;
                    end
                end else if (w_load_use) begin
                    w_ctrl.pc_write    = 1'b0;
                    w_ctrl.if_id_write = 1'b0;
                    w_ctrl.id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_ctrl.dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_state_next = RUN;
                end else begin
                    w_ctrl.pc_write    = 1'b0;
                    w_ctrl.if_id_write = 1'b0;
                    w_ctrl.id_ex_hold  = 1'b1;
                    w_ctrl.ex_mem_hold = 1'b1;
                    w_wait_next        = r_wait + WAIT_W'(1);
                    if (w_wait_next == WAIT_W'(MEM_TIMEOUT)) begin
                        w_state_next = ERR;
                    end
                end
            end
            ERR: begin
                w_ctrl.pc_write    = 1'b0;
                w_ctrl.if_id_write = 1'b0;
                w_ctrl.id_ex_hold  = 1'b1;
                w_ctrl.ex_mem_hold = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase

        if (!rst_n) begin
            w_ctrl = CTRL_FREE;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (~w_ctrl.pc_write),
        .o_count (stall_count)
    );

    assign dmem_req     = w_ctrl.dmem_req;
    assign pc_write     = w_ctrl.pc_write;
    assign if_id_write  = w_ctrl.if_id_write;
    assign id_ex_hold   = w_ctrl.id_ex_hold;
    assign ex_mem_hold  = w_ctrl.ex_mem_hold;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_flush  = w_ctrl.id_ex_flush;
    assign ex_mem_flush = w_ctrl.ex_mem_flush;
    assign pc_src       = w_ctrl.pc_src;
    assign mem_err      = (r_state == ERR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus a randomized run against
// a rule-level reference model.
module tb_hazard_ctrl;

    localparam int TO   = 15;
    localparam int CW   = 5;
    localparam int SMAX = (1 << CW) - 1;

    // {pc_write, if_id_write, id_ex_hold, ex_mem_hold, if_id_flush,
    //  id_ex_flush, ex_mem_flush, pc_src, dmem_req, mem_err}
    localparam logic [9:0] V_IDLE = 10'b1100000000;
    localparam logic [9:0] V_LU   = 10'b0000010000;
    localparam logic [9:0] V_BR   = 10'b1100111100;
    localparam logic [9:0] V_REQ  = 10'b1100000010;
    localparam logic [9:0] V_HOLD = 10'b0011000010;
    localparam logic [9:0] V_ERR  = 10'b0011000001;

    logic          clk;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, id_ex_rd;
    logic          id_ex_MemRead, ex_mem_Branch, ex_mem_zero;
    logic          ex_mem_MemRead, ex_mem_MemWrite, dmem_ack;
    logic          dmem_req, pc_write, if_id_write, id_ex_hold, ex_mem_hold;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mem_err;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_MemRead(id_ex_MemRead),
        .ex_mem_Branch(ex_mem_Branch), .ex_mem_zero(ex_mem_zero),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_src(pc_src),
        .mem_err(mem_err), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {pc_write, if_id_write, id_ex_hold, ex_mem_hold, if_id_flush,
                id_ex_flush, ex_mem_flush, pc_src, dmem_req, mem_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0; id_ex_MemRead = 1'b0;
        ex_mem_Branch = 1'b0; ex_mem_zero = 1'b0;
        ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL reset_outs: got %b want %b", outs(), V_IDLE); end
        total++; if (stall_count !== 5'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
        // hazards presented while reset is low must not reach the outputs
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd3; id_rs1 = 5'd3;
        ex_mem_MemRead = 1'b1; ex_mem_Branch = 1'b1; ex_mem_zero = 1'b1;
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL reset_masks: got %b want %b", outs(), V_IDLE); end
        tick();
        total++; if (stall_count !== 5'd0) begin bad++; $display("FAIL reset_nocount: got %0d want 0", stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd9;
        #1;
        total++; if (outs() !== V_LU) begin bad++; $display("FAIL lu_outs: got %b want %b", outs(), V_LU); end
        tick();
        clear_in();
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL lu_release: got %b want %b", outs(), V_IDLE); end
        total++; if (stall_count !== 5'd1) begin bad++; $display("FAIL lu_stall: got %0d want 1", stall_count); end
    endtask

    task automatic test_load_use_x0();
        do_reset();
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd0; id_rs2 = 5'd0; id_rs1 = 5'd0;
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL x0_outs: got %b want %b", outs(), V_IDLE); end
        tick();
        total++; if (stall_count !== 5'd0) begin bad++; $display("FAIL x0_stall: got %0d want 0", stall_count); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd7;
        ex_mem_Branch = 1'b1; ex_mem_zero = 1'b1; ex_mem_MemRead = 1'b1; dmem_ack = 1'b0;
        #1;
        total++; if (outs() !== V_BR) begin bad++; $display("FAIL br_outs: got %b want %b", outs(), V_BR); end
        tick();
        // branch not taken: memory wait outranks load-use
        ex_mem_zero = 1'b0;
        #1;
        total++; if (outs() !== V_HOLD) begin bad++; $display("FAIL br_nottaken: got %b want %b", outs(), V_HOLD); end
        total++; if (stall_count !== 5'd0) begin bad++; $display("FAIL br_stall: got %0d want 0", stall_count); end
    endtask

    task automatic test_mem_ack3();
        do_reset();
        ex_mem_MemRead = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (outs() !== V_HOLD) begin bad++; $display("FAIL ack3_hold%0d: got %b want %b", i, outs(), V_HOLD); end
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        total++; if (outs() !== V_REQ) begin bad++; $display("FAIL ack3_release: got %b want %b", outs(), V_REQ); end
        tick();
        clear_in();
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL ack3_after: got %b want %b", outs(), V_IDLE); end
        total++; if (stall_count !== 5'd3) begin bad++; $display("FAIL ack3_stall: got %0d want 3", stall_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        ex_mem_MemWrite = 1'b1; dmem_ack = 1'b0;
        #1;
        total++; if (outs() !== V_HOLD) begin bad++; $display("FAIL to_first: got %b want %b", outs(), V_HOLD); end
        tick();
        for (int i = 1; i <= TO; i++) begin
            total++; if (outs() !== V_HOLD) begin bad++; $display("FAIL to_wait%0d: got %b want %b", i, outs(), V_HOLD); end
            tick();
        end
        total++; if (outs() !== V_ERR) begin bad++; $display("FAIL to_err: got %b want %b", outs(), V_ERR); end
        total++; if (stall_count !== 5'(TO + 1)) begin bad++; $display("FAIL to_stall: got %0d want %0d", stall_count, TO + 1); end
        dmem_ack = 1'b1;
        #1;
        total++; if (outs() !== V_ERR) begin bad++; $display("FAIL to_err_ack: got %b want %b", outs(), V_ERR); end
        for (int i = 0; i < 20; i++) tick();
        total++; if (outs() !== V_ERR) begin bad++; $display("FAIL to_err_sticky: got %b want %b", outs(), V_ERR); end
        total++; if (stall_count !== 5'(SMAX)) begin bad++; $display("FAIL to_saturate: got %0d want %0d", stall_count, SMAX); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_in();
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL to_reset: got %b want %b", outs(), V_IDLE); end
        total++; if (stall_count !== 5'd0) begin bad++; $display("FAIL to_reset_stall: got %0d want 0", stall_count); end
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        ex_mem_MemRead = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < TO; i++) tick();
        dmem_ack = 1'b1;
        #1;
        total++; if (outs() !== V_REQ) begin bad++; $display("FAIL ackto_release: got %b want %b", outs(), V_REQ); end
        tick();
        clear_in();
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL ackto_run: got %b want %b", outs(), V_IDLE); end
        total++; if (stall_count !== 5'(TO)) begin bad++; $display("FAIL ackto_stall: got %0d want %0d", stall_count, TO); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_mem_MemRead = 1'b1; dmem_ack = 1'b0;
        tick();
        tick();
        total++; if (outs() !== V_HOLD) begin bad++; $display("FAIL rmw_wait2: got %b want %b", outs(), V_HOLD); end
        rst_n = 1'b0;
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL rmw_during: got %b want %b", outs(), V_IDLE); end
        tick();
        rst_n = 1'b1;
        clear_in();
        #1;
        total++; if (outs() !== V_IDLE) begin bad++; $display("FAIL rmw_after: got %b want %b", outs(), V_IDLE); end
        total++; if (stall_count !== 5'd0) begin bad++; $display("FAIL rmw_stall: got %0d want 0", stall_count); end
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd7;
        #1;
        total++; if (outs() !== V_LU) begin bad++; $display("FAIL rmw_run: got %b want %b", outs(), V_LU); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_mem_MemRead = 1'b1; dmem_ack = 1'b1;
        #1;
        total++; if (outs() !== V_REQ) begin bad++; $display("FAIL b2b_rd: got %b want %b", outs(), V_REQ); end
        tick();
        ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b1;
        #1;
        total++; if (outs() !== V_REQ) begin bad++; $display("FAIL b2b_wr: got %b want %b", outs(), V_REQ); end
        tick();
        clear_in();
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd12; id_rs1 = 5'd12;
        tick();
        tick();
        clear_in();
        #1;
        total++; if (stall_count !== 5'd2) begin bad++; $display("FAIL b2b_stall: got %0d want 2", stall_count); end
    endtask

    task automatic test_random();
        bit m_wait, m_err, taken, memop, lu, hold;
        int m_wc, m_stall;
        logic [9:0] exp;
        logic e_pw, e_f2, e_f13, e_req;
        do_reset();
        m_wait = 0; m_err = 0; m_wc = 0; m_stall = 0;
        for (int i = 0; i < 700; i++) begin
            rst_n           = ($urandom % 40) != 0;
            id_ex_MemRead   = $urandom % 2;
            id_ex_rd        = 5'($urandom % 4);
            id_rs1          = 5'($urandom % 4);
            id_rs2          = 5'($urandom % 4);
            ex_mem_Branch   = ($urandom % 4) == 0;
            ex_mem_zero     = $urandom % 2;
            ex_mem_MemRead  = ($urandom % 5) == 0;
            ex_mem_MemWrite = ($urandom % 5) == 0;
            dmem_ack        = ((i % 150) >= 100 && (i % 150) < 125) ? 1'b0 : (($urandom % 3) == 0);
            #1;
            taken = ex_mem_Branch && ex_mem_zero;
            memop = ex_mem_MemRead || ex_mem_MemWrite;
            lu    = id_ex_MemRead && id_ex_rd != 0 && (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
            hold = 0; e_pw = 1; e_f2 = 0; e_f13 = 0; e_req = 0;
            if (!rst_n) begin
            end else if (m_err) begin
                hold = 1;
            end else if (m_wait) begin
                e_req = 1; hold = !dmem_ack;
            end else if (taken) begin
                e_f13 = 1; e_f2 = 1;
            end else if (memop) begin
                e_req = 1; hold = !dmem_ack;
            end else if (lu) begin
                e_pw = 0; e_f2 = 1;
            end
            if (hold) e_pw = 0;
            exp = {e_pw, e_pw, hold, hold, e_f13, e_f2, e_f13, e_f13, e_req, m_err};
            total++; if (outs() !== exp) begin bad++; $display("FAIL rnd_outs@%0d: got %b want %b", i, outs(), exp); end
            total++; if (stall_count !== 5'(m_stall)) begin bad++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, stall_count, m_stall); end
            tick();
            if (!rst_n) begin
                m_wait = 0; m_err = 0; m_wc = 0; m_stall = 0;
            end else begin
                if (!e_pw && m_stall < SMAX) m_stall++;
                if (m_err) begin
                end else if (m_wait) begin
                    if (dmem_ack) m_wait = 0;
                    else begin
                        m_wc++;
                        if (m_wc == TO) begin m_wait = 0; m_err = 1; end
                    end
                end else if (!taken && memop && !dmem_ack) begin
                    m_wait = 1; m_wc = 0;
                end
            end
        end
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_branch_priority();
        test_mem_ack3();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
